// File: rtl/reset_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings,
// synchroniser depth and a constant-width helper.
package reset_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } rst_state_t;

    localparam int unsigned SYNC_STAGES = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rst_lock_filter.sv
// PLL-lock qualifier: 2-FF synchroniser followed by a stability counter that
// asserts lock_q only after FILTER_CYC consecutive high samples.
module rst_lock_filter
    import reset_pkg::*;
#(
    parameter int unsigned FILTER_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    output logic lock_q
);

    localparam int unsigned     FW   = clog2(FILTER_CYC + 1);
    localparam logic [FW-1:0]   LAST = FW'(FILTER_CYC - 1);
    localparam logic [FW-1:0]   FULL = FW'(FILTER_CYC);

    logic [SYNC_STAGES-1:0] sync;
    logic [FW-1:0]          cnt;
    logic                   lock_reg;
    logic                   lock_sample;

    assign lock_sample = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= '0;
            cnt      <= '0;
            lock_reg <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pll_locked};
            if (!lock_sample) begin
                cnt      <= '0;
                lock_reg <= 1'b0;
            end else if (!lock_reg) begin
                if (cnt == LAST) begin
                    lock_reg <= 1'b1;
                    cnt      <= FULL;
                end else begin
                    cnt <= cnt + FW'(1);
                end
            end
        end
    end

    // A low synchronised sample withdraws lock at once, so the sequencer aborts
    // on the same edge the filter register would clear.
    assign lock_q = lock_reg & lock_sample;

endmodule

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: qualifies PLL lock, holds all channel resets, releases them
// one by one at a fixed stagger and serves per-channel/global software resets.
module reset_seq_ctrl
    import reset_pkg::*;
#(
    parameter int unsigned CH_NUM       = 5,
    parameter int unsigned FILTER_CYC   = 16,
    parameter int unsigned HOLD_CYC     = 64,
    parameter int unsigned STAGGER_CYC  = 8,
    parameter int unsigned SW_PULSE_CYC = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pll_locked,
    input  logic              i_sw_rst_all,
    input  logic [CH_NUM-1:0] i_sw_rst_req,
    output logic [CH_NUM-1:0] o_rst_n,
    output logic              o_rst_done,
    output logic [1:0]        o_state
);

    localparam int unsigned MAX_AB  = (FILTER_CYC > HOLD_CYC) ? FILTER_CYC : HOLD_CYC;
    localparam int unsigned MAX_CD  = (STAGGER_CYC > SW_PULSE_CYC) ? STAGGER_CYC : SW_PULSE_CYC;
    localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = clog2(MAX_ALL + 1);
    localparam int unsigned IDX_W   = clog2(CH_NUM + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAG_LAST  = CNT_W'(STAGGER_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(SW_PULSE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CH_NUM - 1);

    logic [SYNC_STAGES-1:0] rst_sync;
    logic                   rst_int_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[SYNC_STAGES-1];

    logic lock_q;

    rst_lock_filter #(
        .FILTER_CYC (FILTER_CYC)
    ) u_lock_filter (
        .clk        (i_clk),
        .rst_n      (rst_int_n),
        .pll_locked (i_pll_locked),
        .lock_q     (lock_q)
    );

    rst_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [CH_NUM-1:0] pulse_busy;
    logic              abort;

    assign abort    = ((state == ST_RELEASE) || (state == ST_RUN)) && (!lock_q || i_sw_rst_all);
    assign idx_next = idx + IDX_W'(1);

    // Busy covers the request cycle itself plus the remaining SW_PULSE_CYC-1 count.
    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        logic [CNT_W-1:0] pcnt;

        always_ff @(posedge i_clk or negedge rst_int_n) begin
            if (!rst_int_n) begin
                pcnt <= '0;
            end else if (abort) begin
                pcnt <= '0;
            end else if ((state == ST_RUN) && i_sw_rst_req[k]) begin
                pcnt <= PULSE_LOAD;
            end else if (pcnt != '0) begin
                pcnt <= pcnt - CNT_W'(1);
            end
        end

        assign pulse_busy[k] = i_sw_rst_req[k] || (pcnt != '0);
    end

    always_ff @(posedge i_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            idx        <= '0;
            o_rst_n    <= '0;
            o_rst_done <= 1'b0;
        end else if (abort) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            idx        <= '0;
            o_rst_n    <= '0;
            o_rst_done <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    o_rst_n    <= '0;
                    o_rst_done <= 1'b0;
                    idx        <= '0;
                    if (i_sw_rst_all || !lock_q) begin
                        cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        cnt     <= '0;
                        o_rst_n <= CH_NUM'(1);
                        if (CH_NUM == 1) begin
                            state      <= ST_RUN;
                            o_rst_done <= 1'b1;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_RELEASE: begin
                    if (cnt == STAG_LAST) begin
                        cnt     <= '0;
                        idx     <= idx_next;
                        o_rst_n <= o_rst_n | (CH_NUM'(1) << idx_next);
                        if (idx_next == IDX_LAST) begin
                            state      <= ST_RUN;
                            o_rst_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_RUN: begin
                    o_rst_n    <= ~pulse_busy;
                    o_rst_done <= 1'b1;
                end

                default: begin
                    state      <= ST_HOLD;
                    cnt        <= '0;
                    idx        <= '0;
                    o_rst_n    <= '0;
                    o_rst_done <= 1'b0;
                end
            endcase
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Scoreboard bench for reset_seq_ctrl: default instance plus a single-channel
// corner instance; expected edge-indexed outputs are queued and checked by a monitor.
module tb_reset_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, pll, sw_all;
    logic [4:0] sw_req;
    logic [4:0] rst_out;
    logic       done;
    logic [1:0] state;

    logic       rst2_n, pll2, sw_all2;
    logic [0:0] sw_req2;
    logic [0:0] rst_out2;
    logic       done2;
    logic [1:0] state2;

    reset_seq_ctrl #(
        .CH_NUM       (5),
        .FILTER_CYC   (16),
        .HOLD_CYC     (64),
        .STAGGER_CYC  (8),
        .SW_PULSE_CYC (32)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pll_locked (pll),
        .i_sw_rst_all (sw_all),
        .i_sw_rst_req (sw_req),
        .o_rst_n      (rst_out),
        .o_rst_done   (done),
        .o_state      (state)
    );

    reset_seq_ctrl #(
        .CH_NUM       (1),
        .FILTER_CYC   (16),
        .HOLD_CYC     (1),
        .STAGGER_CYC  (1),
        .SW_PULSE_CYC (32)
    ) dut2 (
        .i_clk        (clk),
        .i_rst_n      (rst2_n),
        .i_pll_locked (pll2),
        .i_sw_rst_all (sw_all2),
        .i_sw_rst_req (sw_req2),
        .o_rst_n      (rst_out2),
        .o_rst_done   (done2),
        .o_state      (state2)
    );

    typedef struct {
        int unsigned cyc;
        int unsigned dut_id;
        logic [4:0]  rst;
        logic        dn;
        logic [1:0]  st;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned ecnt = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic push_exp(input int unsigned c, input int unsigned d, input logic [4:0] r,
                            input logic dn, input logic [1:0] st, input string n);
        exp_t e;
        e.cyc = c; e.dut_id = d; e.rst = r; e.dn = dn; e.st = st; e.name = n;
        sb.push_back(e);
    endtask

    // Monitor: compares every queued expectation whose edge has been reached.
    always @(negedge clk) begin : monitor
        logic [4:0] ar;
        logic       ad;
        logic [1:0] as_;
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].cyc <= ecnt) begin
                if (sb[i].dut_id == 1) begin
                    ar = rst_out; ad = done; as_ = state;
                end else begin
                    ar = {4'b0000, rst_out2}; ad = done2; as_ = state2;
                end
                checks++;
                if (sb[i].cyc != ecnt || ar !== sb[i].rst || ad !== sb[i].dn || as_ !== sb[i].st) begin
                    failures++;
                    $display("FAIL %s edge=%0d (want %0d): got rst_n=%b done=%b state=%0d, want rst_n=%b done=%b state=%0d",
                             sb[i].name, ecnt, sb[i].cyc, ar, ad, as_, sb[i].rst, sb[i].dn, sb[i].st);
                end
                sb.delete(i);
            end
        end
    end

    task automatic check_now(input string n, input logic [4:0] ar, input logic ad, input logic [1:0] as_);
        checks++;
        if (ar !== 5'b00000 || ad !== 1'b0 || as_ !== 2'd0) begin
            failures++;
            $display("FAIL %s: got rst_n=%b done=%b state=%0d, want rst_n=00000 done=0 state=0", n, ar, ad, as_);
        end
    endtask

    task automatic wait_edge(input int unsigned n);
        while (ecnt < n) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int unsigned t0, t, s, p, l, r, g;
        rst_n = 1'b0; pll = 1'b1; sw_all = 1'b0; sw_req = '0;
        rst2_n = 1'b0; pll2 = 1'b1; sw_all2 = 1'b0; sw_req2 = '0;
        repeat (3) @(negedge clk);
        push_exp(ecnt + 1, 1, 5'b00000, 1'b0, 2'd0, "reset_state");
        push_exp(ecnt + 1, 2, 5'b00000, 1'b0, 2'd0, "reset_state_ch1");
        @(negedge clk);

        // Power-up with lock already high.
        t0 = ecnt;
        rst_n = 1'b1; rst2_n = 1'b1;
        push_exp(t0 + 20,  2, 5'b00000, 1'b0, 2'd0, "ch1_before_release");
        push_exp(t0 + 21,  2, 5'b00001, 1'b1, 2'd2, "ch1_release_done");
        push_exp(t0 + 50,  1, 5'b00000, 1'b0, 2'd0, "hold_mid");
        push_exp(t0 + 83,  1, 5'b00000, 1'b0, 2'd0, "hold_last");
        push_exp(t0 + 84,  1, 5'b00001, 1'b0, 2'd1, "bit0_rise");
        push_exp(t0 + 91,  1, 5'b00001, 1'b0, 2'd1, "bit1_not_yet");
        push_exp(t0 + 92,  1, 5'b00011, 1'b0, 2'd1, "bit1_rise");
        push_exp(t0 + 100, 1, 5'b00111, 1'b0, 2'd1, "bit2_rise");
        push_exp(t0 + 108, 1, 5'b01111, 1'b0, 2'd1, "bit3_rise");
        push_exp(t0 + 115, 1, 5'b01111, 1'b0, 2'd1, "bit4_not_yet");
        push_exp(t0 + 116, 1, 5'b11111, 1'b1, 2'd2, "run_entry");
        wait_edge(t0 + 120);

        // Per-channel pulse of 32 cycles on channel 2.
        t = ecnt;
        sw_req = 5'b00100;
        push_exp(t + 1,  1, 5'b11011, 1'b1, 2'd2, "pulse_start");
        push_exp(t + 32, 1, 5'b11011, 1'b1, 2'd2, "pulse_last_low");
        push_exp(t + 33, 1, 5'b11111, 1'b1, 2'd2, "pulse_end");
        @(negedge clk);
        sw_req = '0;
        wait_edge(t + 40);

        // Re-pulse 20 cycles in extends the low time to 52 cycles.
        s = ecnt;
        sw_req = 5'b00100;
        push_exp(s + 1,  1, 5'b11011, 1'b1, 2'd2, "repulse_start");
        push_exp(s + 33, 1, 5'b11011, 1'b1, 2'd2, "repulse_extended");
        push_exp(s + 52, 1, 5'b11011, 1'b1, 2'd2, "repulse_last_low");
        push_exp(s + 53, 1, 5'b11111, 1'b1, 2'd2, "repulse_end");
        @(negedge clk);
        sw_req = '0;
        wait_edge(s + 20);
        sw_req = 5'b00100;
        @(negedge clk);
        sw_req = '0;
        wait_edge(s + 60);

        // Global reset with a concurrent channel request, then a request during RELEASE.
        p = ecnt;
        sw_all = 1'b1; sw_req = 5'b00010;
        push_exp(p + 1,  1, 5'b00000, 1'b0, 2'd0, "sw_all_abort");
        push_exp(p + 64, 1, 5'b00000, 1'b0, 2'd0, "sw_all_hold_last");
        push_exp(p + 65, 1, 5'b00001, 1'b0, 2'd1, "sw_all_bit0");
        @(negedge clk);
        sw_all = 1'b0; sw_req = '0;
        wait_edge(p + 66);
        sw_req = 5'b00001;
        push_exp(p + 67, 1, 5'b00001, 1'b0, 2'd1, "release_req_ignored");
        push_exp(p + 73, 1, 5'b00011, 1'b0, 2'd1, "release_bit1");
        push_exp(p + 96, 1, 5'b01111, 1'b0, 2'd1, "release_bit3");
        push_exp(p + 97, 1, 5'b11111, 1'b1, 2'd2, "rerun_entry");
        @(negedge clk);
        sw_req = '0;
        wait_edge(p + 100);

        // Lock loss in RUN, restore, then a 1-cycle glitch in HOLD.
        l = ecnt;
        pll = 1'b0;
        push_exp(l + 2, 1, 5'b11111, 1'b1, 2'd2, "lockloss_edge2");
        push_exp(l + 3, 1, 5'b00000, 1'b0, 2'd0, "lockloss_edge3");
        wait_edge(l + 10);
        r = ecnt;
        pll = 1'b1;
        push_exp(r + 40, 1, 5'b00000, 1'b0, 2'd0, "relock_hold");
        wait_edge(r + 40);
        g = ecnt;
        pll = 1'b0;
        push_exp(r + 82, 1, 5'b00000, 1'b0, 2'd0, "glitch_delays_release");
        push_exp(g + 82, 1, 5'b00000, 1'b0, 2'd0, "glitch_hold_last");
        push_exp(g + 83, 1, 5'b00001, 1'b0, 2'd1, "glitch_bit0");
        push_exp(g + 91, 1, 5'b00011, 1'b0, 2'd1, "glitch_bit1");
        push_exp(g + 95, 1, 5'b00011, 1'b0, 2'd1, "mid_release");
        push_exp(g + 95, 2, 5'b00001, 1'b1, 2'd2, "ch1_steady_run");
        @(negedge clk);
        pll = 1'b1;
        wait_edge(g + 95);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0; rst2_n = 1'b0;
        #1;
        check_now("async_reset", rst_out, done, state);
        check_now("async_reset_ch1", {4'b0000, rst_out2}, done2, state2);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reset_seq_ctrl.md
# reset_seq_ctrl

Parametrised reset sequencer for the TSN switch core clock domain. It qualifies a raw PLL-lock input through a synchroniser and stability filter, then holds every downstream reset for a minimum time. It releases CH_NUM channel resets one at a time, spaced a fixed interval apart, and supports per-channel and global software reset requests during normal operation.

## Interface
Parameters:
- CH_NUM, 5: number of reset channels (1..32).
- FILTER_CYC, 16: consecutive synchronised-high lock samples required to qualify lock (≥1).
- HOLD_CYC, 64: cycles all channels stay asserted after lock qualifies (≥1).
- STAGGER_CYC, 8: cycles between successive channel releases (≥1).
- SW_PULSE_CYC, 32: per-channel software reset pulse length (≥1).

Ports:
- i_clk  in  1  single clock for the whole block.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_pll_locked  in  1  raw asynchronous lock indication.
- i_sw_rst_all  in  1  single-cycle request to restart the full sequence.
- i_sw_rst_req  in  CH_NUM  per-channel single-cycle reset requests.
- o_rst_n  out  CH_NUM  active-low channel resets; bit k releases k-th.
- o_rst_done  out  1  high once all channels are released and the block is in RUN.
- o_state  out  2  current FSM state encoding.

## Operation
- Internal reset: i_rst_n asserts asynchronously. Deassertion passes a 2-FF synchroniser; all logic uses the synchronised reset.
- Reset values: o_rst_n=0 (all bits), o_rst_done=0, o_state=HOLD(0). Internal counters and channel index are 0.
- Lock filter:
  - i_pll_locked passes a 2-FF synchroniser.
  - lock_q sets after FILTER_CYC consecutive high samples.
  - Any low sample clears lock_q and the filter count on the next edge.
- FSM states: HOLD=0, RELEASE=1, RUN=2 (3 unused; decodes to HOLD).
  - HOLD: o_rst_n all 0. Counter increments while lock_q=1 and clears when lock_q=0. When the counter reaches HOLD_CYC-1, go to RELEASE and set o_rst_n[0]=1 on the same edge.
  - RELEASE: every STAGGER_CYC cycles, release the next channel in index order. On the edge that releases bit CH_NUM-1, go to RUN and set o_rst_done=1.
  - CH_NUM=1: HOLD goes directly to RUN, and bit 0 and o_rst_done rise together.
  - RUN: stay until an abort condition occurs.
- Abort (lock_q falls, or i_sw_rst_all=1) in RELEASE or RUN:
  - Next edge: o_rst_n=0 (all bits), o_rst_done=0, all per-channel pulse counters cleared, state HOLD, hold counter restarts at 0.
  - i_sw_rst_all in HOLD restarts the hold count.
- Per-channel software reset, honoured in RUN only:
  - i_sw_rst_req[k]=1 drives o_rst_n[k]=0 on the next edge and loads that channel's counter with SW_PULSE_CYC-1.
  - The channel stays low for exactly SW_PULSE_CYC cycles.
  - A new request during the pulse reloads the counter (pulse extends).
  - Requests in HOLD or RELEASE are ignored.
  - o_rst_done stays 1 during per-channel pulses.
- Simultaneous events: abort has priority over per-channel requests. Multiple channel requests in one cycle are all honoured.
- Counter width: CNT_W = clog2(max(FILTER_CYC,HOLD_CYC,STAGGER_CYC,SW_PULSE_CYC)+1), unsigned, no wrap (saturate at terminal value).

## Timing
- All outputs are registered and glitch-free; no combinational path from any input to any output.
- Startup latency, measured from the first edge with i_rst_n sampled high and i_pll_locked already high, counted in edges:
  - o_rst_n[0] rises at edge 4+FILTER_CYC+HOLD_CYC (84 with defaults).
  - o_rst_n[k] rises k·STAGGER_CYC edges after o_rst_n[0].
- Lock loss: lock low to all o_rst_n=0 takes 3 edges (2 sync + 1 filter). From i_sw_rst_all to all o_rst_n=0 takes 1 edge.
- i_rst_n asserted mid-sequence: all outputs go to reset values immediately, asynchronously.

## Structure
- Shared package reset_pkg holds the state encodings HOLD/RELEASE/RUN, the 2-FF sync depth constant (2), and a clog2 helper function.
- Sub-module rst_lock_filter (parameter FILTER_CYC) contains the 2-FF synchroniser and stability counter and outputs lock_q.
- The FSM, stagger logic and per-channel pulse counters live in the top module. Per-channel counters are generated with a generate loop over CH_NUM.

## Test plan
Defaults apply unless stated.
- Power-up: release i_rst_n with lock high -> o_rst_n[0] rises at edge 84; bits 1..4 rise at 92, 100, 108, 116; o_rst_done=1 and o_state=2 at edge 116.
- Lock glitch: lock low for 1 cycle during HOLD -> hold count restarts; o_rst_n[0] is delayed by the full filter plus hold time after lock returns.
- Lock loss in RUN: drop lock -> all o_rst_n=0 and o_rst_done=0 within 3 edges; restore lock -> full staggered sequence repeats.
- Per-channel reset: i_sw_rst_req=5'b00100 in RUN -> o_rst_n[2]=0 for exactly 32 cycles, other bits stay 1; a re-pulse at cycle 20 extends the low time to 52 cycles.
- Priority: i_sw_rst_all together with i_sw_rst_req[1] in RUN -> all bits 0 next edge, state HOLD; a request during RELEASE is ignored.
- Corner configuration: CH_NUM=1, HOLD_CYC=1, STAGGER_CYC=1 -> o_rst_n[0] and o_rst_done rise together at edge 4+FILTER_CYC+1; async i_rst_n assertion mid-RELEASE clears all outputs with no clock edge.
